register_file: RTL and testbench
================================

Name: register_file

Overview:
- Parametrised multi-entry successor to the single `register` storage element.
- Holds 2**ADDR_WIDTH words of BUS_WIDTH bits each.
- One synchronous write port and two independent combinational read ports.
- Optional same-cycle write-through bypass and optional hardwired-zero entry 0.
- Sits in the memory library as the datapath register bank for CPU-style designs.

Parameters:
BUS_WIDTH, 8, data word width in bits (>=1)
ADDR_WIDTH, 3, address width; DEPTH = 2**ADDR_WIDTH entries (>=1)
BYPASS, 0, 1 = read of the address being written returns write data in the same cycle; 0 = returns old contents until the clock edge
ZERO_REG, 0, 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is ordinary storage

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset; sampled on rising edge of clk
st  input  1  write strobe; sampled on rising edge of clk
wa  input  ADDR_WIDTH  write address
d  input  BUS_WIDTH  write data
ra_a  input  ADDR_WIDTH  read address, port A
o_a  output  BUS_WIDTH  read data, port A
ra_b  input  ADDR_WIDTH  read address, port B
o_b  output  BUS_WIDTH  read data, port B

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. No asynchronous paths into storage.
- Reset: on a rising edge with rst=1, every entry is cleared to 0.
  - rst has priority over st; a write presented in the reset cycle is dropped.
  - After that edge, o_a = o_b = 0 for every address.
  - Before the edge, outputs still show the old contents.
  - Reset asserted mid-sequence behaves identically; there is no partial clear.
- Write: on a rising edge with rst=0 and st=1, mem[wa] <= d.
  - Latency is one edge; the value is visible on the read ports immediately after that edge.
  - With st=0, storage holds.
- Read: o_x = mem[ra_x], purely combinational from ra_x and storage; no read latency, no read enable.
  - Both ports may address the same entry and then return identical data.
- Bypass, BYPASS=1: when st=1, rst=0 and ra_x == wa, o_x = d combinationally in the same cycle.
  - Applies per port independently; follows d if d changes within the cycle.
  - rst=1 suppresses the bypass; o_x shows stored contents.
- Bypass, BYPASS=0: o_x shows the pre-write contents until the edge.
- ZERO_REG=1:
  - o_x = 0 whenever ra_x == 0, regardless of storage, bypass or st.
  - Writes to wa=0 are discarded; the storage for entry 0 may be optimised away.
- Widths: d is stored without truncation or extension; addresses cover exactly DEPTH entries, so no out-of-range case exists.
- Storage is undefined (X) before the first reset edge. Benches must reset first.
- No internal state beyond the storage array; no handshake, back-pressure or busy signal. A write can be accepted every cycle.

Test Plan:
- Reset clear: write 8'hA5 to addr 5 then assert rst=1 for one edge -> o_a(ra_a=5) = 0, o_b(ra_b=7) = 0.
- Write/read both ports: st=1, wa=3, d=30; edge; st=0 -> o_a(ra_a=3) = 30, o_b(ra_b=3) = 30; addr 2 still 0.
- Hold and overwrite: write 31 to addr 1; st=0 with d=32 for 2 edges -> addr 1 reads 31. Then write 33 -> addr 1 reads 33 after the edge.
- Reset vs write collision: rst=1, st=1, wa=4, d=15 on the same edge -> addr 4 reads 0, not 15.
- Bypass:
  - BYPASS=1: write 8'h3C to addr 6, then st=1, wa=6, d=8'h7E, ra_a=6 before the edge -> o_a = 8'h7E.
  - BYPASS=0, same stimulus -> o_a = 8'h3C before the edge, 8'h7E after it.
- Zero register: ZERO_REG=1, write 8'hFF to addr 0 (BYPASS=1) -> o_a(ra_a=0) = 0 before and after the edge. Same test with ZERO_REG=0 -> reads 8'hFF after the edge.

Source files
------------

// File: rtl/register_file.sv
// register_file: 2**ADDR_WIDTH x BUS_WIDTH register bank, one synchronous write port, two combinational read ports.
// Write lands on the next rising edge, reads have zero latency; no backpressure, a write is accepted every cycle.
module register_file #(
  parameter int BUS_WIDTH  = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int BYPASS     = 0,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  st,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [BUS_WIDTH-1:0]  d,
  input  logic [ADDR_WIDTH-1:0] ra_a,
  output logic [BUS_WIDTH-1:0]  o_a,
  input  logic [ADDR_WIDTH-1:0] ra_b,
  output logic [BUS_WIDTH-1:0]  o_b
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [BUS_WIDTH-1:0]  r_mem [DEPTH];
  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_ra [2];
  logic [BUS_WIDTH-1:0]  w_rd [2];

  // Entry 0 never accepts a write when it is hardwired to zero.
  assign w_wr_en = st && !((ZERO_REG != 0) && (wa == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[wa] <= d;
    end
  end

  assign w_ra[0] = ra_a;
  assign w_ra[1] = ra_b;

  // Zero-entry override outranks bypass, which outranks the stored word.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rd[p] = r_mem[w_ra[p]];
      if ((BYPASS != 0) && st && !rst && (w_ra[p] == wa)) begin
        w_rd[p] = d;
      end
      if ((ZERO_REG != 0) && (w_ra[p] == '0)) begin
        w_rd[p] = '0;
      end
    end
  end

  assign o_a = w_rd[0];
  assign o_b = w_rd[1];

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: four instances covering every BYPASS/ZERO_REG combination,
// driven in parallel and checked against an array model of the storage rules.
module tb_register_file;

  logic       clk;
  logic       rst;
  logic       st;
  logic [2:0] wa;
  logic [7:0] d;
  logic [2:0] ra_a;
  logic [2:0] ra_b;
  logic [7:0] oa [4];
  logic [7:0] ob [4];

  int checks;
  int failures;

  // Reference storage; instance k has BYPASS = k[0], ZERO_REG = k[1].
  logic [7:0] m_mem [8];

  register_file #(.BUS_WIDTH(8), .ADDR_WIDTH(3), .BYPASS(0), .ZERO_REG(0)) u_b0z0 (
    .clk(clk), .rst(rst), .st(st), .wa(wa), .d(d),
    .ra_a(ra_a), .o_a(oa[0]), .ra_b(ra_b), .o_b(ob[0]));
  register_file #(.BUS_WIDTH(8), .ADDR_WIDTH(3), .BYPASS(1), .ZERO_REG(0)) u_b1z0 (
    .clk(clk), .rst(rst), .st(st), .wa(wa), .d(d),
    .ra_a(ra_a), .o_a(oa[1]), .ra_b(ra_b), .o_b(ob[1]));
  register_file #(.BUS_WIDTH(8), .ADDR_WIDTH(3), .BYPASS(0), .ZERO_REG(1)) u_b0z1 (
    .clk(clk), .rst(rst), .st(st), .wa(wa), .d(d),
    .ra_a(ra_a), .o_a(oa[2]), .ra_b(ra_b), .o_b(ob[2]));
  register_file #(.BUS_WIDTH(8), .ADDR_WIDTH(3), .BYPASS(1), .ZERO_REG(1)) u_b1z1 (
    .clk(clk), .rst(rst), .st(st), .wa(wa), .d(d),
    .ra_a(ra_a), .o_a(oa[3]), .ra_b(ra_b), .o_b(ob[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] exp_rd(input logic [2:0] ra, input int k);
    if (k[1] && ra == 3'd0) return 8'h00;
    if (k[0] && st && !rst && ra == wa) return d;
    return m_mem[ra];
  endfunction

  // Apply the current inputs to the model, then advance past the edge.
  task automatic tick();
    if (rst) begin
      for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
    end else if (st) begin
      m_mem[wa] = d;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; st = 1'b0; wa = 3'd0; d = 8'h00; ra_a = 3'd0; ra_b = 3'd0;
    tick();
    rst = 1'b0;
    for (int a = 0; a < 8; a++) begin
      ra_a = 3'(a); ra_b = 3'(7 - a);
      #1;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (oa[k] !== 8'h00) begin
          failures++; $display("FAIL reset_clear inst%0d o_a addr%0d got=%h exp=00", k, a, oa[k]);
        end
        checks++;
        if (ob[k] !== 8'h00) begin
          failures++; $display("FAIL reset_clear inst%0d o_b addr%0d got=%h exp=00", k, 7 - a, ob[k]);
        end
      end
    end
    st = 1'b1; wa = 3'd5; d = 8'hA5;
    tick();
    st = 1'b0; rst = 1'b1; ra_a = 3'd5; ra_b = 3'd7;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (oa[k] !== 8'hA5) begin
        failures++; $display("FAIL reset_pre_edge inst%0d o_a got=%h exp=a5", k, oa[k]);
      end
    end
    tick();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (oa[k] !== 8'h00 || ob[k] !== 8'h00) begin
        failures++; $display("FAIL reset_mid inst%0d o_a=%h o_b=%h exp=00/00", k, oa[k], ob[k]);
      end
    end
  endtask

  task automatic test_write_read();
    st = 1'b1; wa = 3'd3; d = 8'd30; ra_a = 3'd2; ra_b = 3'd2;
    tick();
    st = 1'b0; ra_a = 3'd3; ra_b = 3'd3;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (oa[k] !== 8'd30 || ob[k] !== 8'd30) begin
        failures++; $display("FAIL write_read inst%0d o_a=%0d o_b=%0d exp=30/30", k, oa[k], ob[k]);
      end
    end
    ra_a = 3'd2;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (oa[k] !== 8'd0) begin
        failures++; $display("FAIL untouched_addr2 inst%0d got=%0d exp=0", k, oa[k]);
      end
    end
  endtask

  task automatic test_hold_overwrite();
    st = 1'b1; wa = 3'd1; d = 8'd31;
    tick();
    st = 1'b0; d = 8'd32;
    tick();
    tick();
    ra_a = 3'd1; ra_b = 3'd1;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (oa[k] !== 8'd31 || ob[k] !== 8'd31) begin
        failures++; $display("FAIL hold inst%0d o_a=%0d o_b=%0d exp=31", k, oa[k], ob[k]);
      end
    end
    st = 1'b1; d = 8'd33;
    tick();
    st = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (oa[k] !== 8'd33) begin
        failures++; $display("FAIL overwrite inst%0d got=%0d exp=33", k, oa[k]);
      end
    end
  endtask

  task automatic test_reset_collision();
    st = 1'b1; wa = 3'd4; d = 8'h09;
    tick();
    rst = 1'b1; st = 1'b1; wa = 3'd4; d = 8'd15; ra_a = 3'd4; ra_b = 3'd4;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (oa[k] !== 8'h09) begin
        failures++; $display("FAIL collision_no_bypass inst%0d got=%h exp=09", k, oa[k]);
      end
    end
    tick();
    rst = 1'b0; st = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (oa[k] !== 8'h00 || ob[k] !== 8'h00) begin
        failures++; $display("FAIL collision_dropped inst%0d o_a=%h o_b=%h exp=00", k, oa[k], ob[k]);
      end
    end
  endtask

  task automatic test_bypass();
    logic [7:0] e;
    st = 1'b1; wa = 3'd6; d = 8'h3C;
    tick();
    d = 8'h7E; ra_a = 3'd6; ra_b = 3'd5;
    #1;
    for (int k = 0; k < 4; k++) begin
      e = k[0] ? 8'h7E : 8'h3C;
      checks++;
      if (oa[k] !== e) begin
        failures++; $display("FAIL bypass_pre_edge inst%0d got=%h exp=%h", k, oa[k], e);
      end
      checks++;
      if (ob[k] !== 8'h00) begin
        failures++; $display("FAIL bypass_other_port inst%0d got=%h exp=00", k, ob[k]);
      end
    end
    d = 8'h5A; ra_b = 3'd6;
    #1;
    for (int k = 0; k < 4; k++) begin
      e = k[0] ? 8'h5A : 8'h3C;
      checks++;
      if (oa[k] !== e || ob[k] !== e) begin
        failures++; $display("FAIL bypass_follow_d inst%0d o_a=%h o_b=%h exp=%h", k, oa[k], ob[k], e);
      end
    end
    tick();
    st = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (oa[k] !== 8'h5A) begin
        failures++; $display("FAIL bypass_post_edge inst%0d got=%h exp=5a", k, oa[k]);
      end
    end
  endtask

  task automatic test_zero_reg();
    logic [7:0] e;
    st = 1'b1; wa = 3'd0; d = 8'hFF; ra_a = 3'd0; ra_b = 3'd0;
    #1;
    for (int k = 0; k < 4; k++) begin
      e = k[1] ? 8'h00 : (k[0] ? 8'hFF : 8'h00);
      checks++;
      if (oa[k] !== e) begin
        failures++; $display("FAIL zero_pre_edge inst%0d got=%h exp=%h", k, oa[k], e);
      end
    end
    tick();
    st = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      e = k[1] ? 8'h00 : 8'hFF;
      checks++;
      if (oa[k] !== e || ob[k] !== e) begin
        failures++; $display("FAIL zero_post_edge inst%0d o_a=%h o_b=%h exp=%h", k, oa[k], ob[k], e);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst  = ($urandom_range(0, 31) == 0);
      st   = 1'($urandom_range(0, 1));
      wa   = 3'($urandom_range(0, 7));
      d    = 8'($urandom);
      ra_a = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
      ra_b = 3'($urandom_range(0, 7));
      #1;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (oa[k] !== exp_rd(ra_a, k) || ob[k] !== exp_rd(ra_b, k)) begin
          failures++;
          $display("FAIL random_pre n=%0d inst%0d o_a=%h/%h o_b=%h/%h (got/exp)",
                   n, k, oa[k], exp_rd(ra_a, k), ob[k], exp_rd(ra_b, k));
        end
      end
      tick();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (oa[k] !== exp_rd(ra_a, k) || ob[k] !== exp_rd(ra_b, k)) begin
          failures++;
          $display("FAIL random_post n=%0d inst%0d o_a=%h/%h o_b=%h/%h (got/exp)",
                   n, k, oa[k], exp_rd(ra_a, k), ob[k], exp_rd(ra_b, k));
        end
      end
    end
    rst = 1'b0; st = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0; st = 1'b0; wa = 3'd0; d = 8'h00; ra_a = 3'd0; ra_b = 3'd0;
    test_reset();
    test_write_read();
    test_hold_overwrite();
    test_reset_collision();
    test_bypass();
    test_zero_reg();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
